// File: rtl/stream_mux_n_rr.sv
// stream_mux_n_rr: N:1 packet-aware valid/ready stream multiplexer.
// The source channel comes from the select bus (MODE 0) or from a round-robin
// arbiter (MODE 1). A granted channel keeps the grant until its last beat.
// The output is a single register stage with full throughput.
module stream_mux_n_rr #(
  parameter int WIDTH    = 16,
  parameter int CHANNELS = 10,
  parameter int SEL_W    = 8,
  parameter int MODE     = 0
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [SEL_W-1:0]          select,
  input  logic [CHANNELS*WIDTH-1:0] in_data,
  input  logic [CHANNELS-1:0]       in_valid,
  input  logic [CHANNELS-1:0]       in_last,
  output logic [CHANNELS-1:0]       in_ready,
  output logic [WIDTH-1:0]          out_data,
  output logic                      out_valid,
  output logic                      out_last,
  output logic [SEL_W-1:0]          out_chan,
  input  logic                      out_ready,
  output logic                      sel_err
);

  // Channel count widened by one bit so CHANNELS == 2**SEL_W still compares correctly.
  localparam logic [SEL_W:0]   CH_L      = (SEL_W + 1)'(CHANNELS);
  localparam logic [SEL_W-1:0] CH_LAST_L = SEL_W'(CHANNELS - 1);
  localparam logic             MODE_RR_L = (MODE != 32'sd0);

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } state_t;

  state_t             state_r;
  logic [SEL_W-1:0]   lock_ch_r;
  logic [SEL_W-1:0]   rr_ptr_r;
  logic [WIDTH-1:0]   out_data_r;
  logic               out_valid_r;
  logic               out_last_r;
  logic [SEL_W-1:0]   out_chan_r;
  logic               sel_err_r;

  logic               sel_ok_s;
  logic [SEL_W-1:0]   rr_grant_s;
  logic               rr_found_s;
  logic [SEL_W-1:0]   grant_s;
  logic               cand_s;
  logic [WIDTH-1:0]   g_data_s;
  logic               g_valid_s;
  logic               g_last_s;
  logic               grant_valid_s;
  logic               load_en_s;
  logic               xfer_s;
  logic [SEL_W-1:0]   rr_next_s;
  logic [CHANNELS-1:0] in_ready_s;
  int                 ptr_v;
  int                 dist_v;
  int                 best_v;

  // Select bus addresses an existing channel.
  always_comb begin
    sel_ok_s = ({1'b0, select} < CH_L);
  end

  // Round-robin pick: valid channel with the smallest wrapped distance from the pointer.
  always_comb begin
    rr_grant_s = '0;
    rr_found_s = 1'b0;
    ptr_v      = int'(rr_ptr_r);
    dist_v     = 0;
    best_v     = CHANNELS;
    for (int i = 0; i < CHANNELS; i++) begin
      if (i >= ptr_v) begin
        dist_v = i - ptr_v;
      end else begin
        dist_v = i + CHANNELS - ptr_v;
      end
      if (in_valid[i] && (dist_v < best_v)) begin
        best_v     = dist_v;
        rr_grant_s = SEL_W'(i);
        rr_found_s = 1'b1;
      end else begin
        best_v = best_v;
      end
    end
  end

  // Grant source: held channel while locked, otherwise select bus or arbiter.
  always_comb begin
    grant_s = '0;
    cand_s  = 1'b0;
    case (state_r)
      ST_LOCKED: begin
        grant_s = lock_ch_r;
        cand_s  = 1'b1;
      end
      ST_IDLE: begin
        if (MODE_RR_L) begin
          grant_s = rr_grant_s;
          cand_s  = rr_found_s;
        end else begin
          grant_s = select;
          cand_s  = sel_ok_s;
        end
      end
      default: begin
        grant_s = '0;
        cand_s  = 1'b0;
      end
    endcase
  end

  // Route the granted channel's data, valid and last.
  always_comb begin
    g_data_s  = '0;
    g_valid_s = 1'b0;
    g_last_s  = 1'b0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (grant_s == SEL_W'(i)) begin
        g_data_s  = in_data[i*WIDTH +: WIDTH];
        g_valid_s = in_valid[i];
        g_last_s  = in_last[i];
      end else begin
        g_data_s  = g_data_s;
      end
    end
  end

  // Handshake: the output register may load when empty or being drained.
  always_comb begin
    load_en_s     = !out_valid_r || out_ready;
    grant_valid_s = cand_s && g_valid_s;
    xfer_s        = !rst && load_en_s && grant_valid_s;
    if (grant_s == CH_LAST_L) begin
      rr_next_s = '0;
    end else begin
      rr_next_s = grant_s + SEL_W'(1);
    end
  end

  // One-hot accept towards the granted channel only.
  always_comb begin
    in_ready_s = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      in_ready_s[i] = xfer_s && (grant_s == SEL_W'(i));
    end
  end

  // Packet FSM, round-robin pointer and registered output stage.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      lock_ch_r   <= '0;
      rr_ptr_r    <= '0;
      out_data_r  <= '0;
      out_valid_r <= 1'b0;
      out_last_r  <= 1'b0;
      out_chan_r  <= '0;
      sel_err_r   <= 1'b0;
    end else begin
      sel_err_r <= !MODE_RR_L && (state_r == ST_IDLE) && !sel_ok_s;
      if (load_en_s) begin
        if (xfer_s) begin
          out_data_r  <= g_data_s;
          out_last_r  <= g_last_s;
          out_chan_r  <= grant_s;
          out_valid_r <= 1'b1;
          if (g_last_s) begin
            state_r  <= ST_IDLE;
            rr_ptr_r <= rr_next_s;
          end else begin
            state_r   <= ST_LOCKED;
            lock_ch_r <= grant_s;
          end
        end else begin
          out_valid_r <= 1'b0;
        end
      end else begin
        out_valid_r <= out_valid_r;
      end
    end
  end

  assign in_ready  = in_ready_s;
  assign out_data  = out_data_r;
  assign out_valid = out_valid_r;
  assign out_last  = out_last_r;
  assign out_chan  = out_chan_r;
  assign sel_err   = sel_err_r;

endmodule

// File: tb/tb_stream_mux_n_rr.sv
// Bench for stream_mux_n_rr: instance 0 runs MODE 0 (select), instance 1 runs
// MODE 1 (round-robin). A behavioural per-cycle model predicts every output.
module tb_stream_mux_n_rr;
  localparam int CH = 10;
  localparam int W  = 16;
  localparam int SW = 8;

  logic              clk = 1'b0;
  logic              rst       [2];
  logic [SW-1:0]     sel       [2];
  logic [CH*W-1:0]   in_data   [2];
  logic [CH-1:0]     in_valid  [2];
  logic [CH-1:0]     in_last   [2];
  logic [CH-1:0]     in_ready  [2];
  logic              out_ready [2];
  logic [W-1:0]      out_data  [2];
  logic              out_valid [2];
  logic              out_last  [2];
  logic [SW-1:0]     out_chan  [2];
  logic              sel_err   [2];

  int n_assert = 0;
  int n_fail   = 0;

  // model state
  int          m_ov[2], m_ol[2], m_oc[2], m_err[2], m_lk[2], m_lch[2], m_ptr[2];
  logic [W-1:0] m_od[2];
  int          e_g[2];
  bit          e_x[2];
  logic [CH-1:0] rdy_seen[2];
  logic [W-1:0]  rx[$];

  always #5 clk = ~clk;

  stream_mux_n_rr #(.WIDTH(W), .CHANNELS(CH), .SEL_W(SW), .MODE(0)) u_sel (
    .clk(clk), .rst(rst[0]), .select(sel[0]), .in_data(in_data[0]),
    .in_valid(in_valid[0]), .in_last(in_last[0]), .in_ready(in_ready[0]),
    .out_data(out_data[0]), .out_valid(out_valid[0]), .out_last(out_last[0]),
    .out_chan(out_chan[0]), .out_ready(out_ready[0]), .sel_err(sel_err[0]));

  stream_mux_n_rr #(.WIDTH(W), .CHANNELS(CH), .SEL_W(SW), .MODE(1)) u_rr (
    .clk(clk), .rst(rst[1]), .select(sel[1]), .in_data(in_data[1]),
    .in_valid(in_valid[1]), .in_last(in_last[1]), .in_ready(in_ready[1]),
    .out_data(out_data[1]), .out_valid(out_valid[1]), .out_last(out_last[1]),
    .out_chan(out_chan[1]), .out_ready(out_ready[1]), .sel_err(sel_err[1]));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Which channel the rules grant this cycle and whether a beat moves.
  task automatic model_comb(input int d);
    bit cand;
    int g;
    int c;
    cand = 1'b0;
    g = 0;
    if (m_lk[d] != 0) begin
      g = m_lch[d];
      cand = 1'b1;
    end else if (d == 0) begin
      g = int'(sel[0]);
      cand = (g < CH);
    end else begin
      for (int k = 0; k < CH; k++) begin
        c = (m_ptr[d] + k) % CH;
        if (!cand && in_valid[d][c]) begin
          g = c;
          cand = 1'b1;
        end
      end
    end
    e_g[d] = g;
    e_x[d] = 1'b0;
    if (!rst[d] && cand && (m_ov[d] == 0 || out_ready[d]))
      e_x[d] = in_valid[d][g];
  endtask

  // Register update at the clock edge.
  task automatic model_seq(input int d);
    int g;
    g = e_g[d];
    if (rst[d]) begin
      m_ov[d] = 0; m_ol[d] = 0; m_oc[d] = 0; m_od[d] = '0;
      m_err[d] = 0; m_lk[d] = 0; m_lch[d] = 0; m_ptr[d] = 0;
    end else begin
      m_err[d] = (d == 0 && m_lk[d] == 0 && int'(sel[0]) >= CH) ? 1 : 0;
      if (m_ov[d] == 0 || out_ready[d]) begin
        if (e_x[d]) begin
          m_ov[d] = 1;
          m_od[d] = in_data[d][g*W +: W];
          m_ol[d] = int'(in_last[d][g]);
          m_oc[d] = g;
          if (in_last[d][g]) begin
            m_lk[d] = 0;
            m_ptr[d] = (g + 1) % CH;
          end else begin
            m_lk[d] = 1;
            m_lch[d] = g;
          end
        end else begin
          m_ov[d] = 0;
        end
      end
    end
  endtask

  task automatic cycle();
    logic [CH-1:0] er;
    #1;
    for (int d = 0; d < 2; d++) begin
      model_comb(d);
      er = '0;
      if (e_x[d]) er[e_g[d]] = 1'b1;
      chk($sformatf("in_ready%0d", d), 32'(in_ready[d]), 32'(er));
      rdy_seen[d] = in_ready[d];
    end
    if (out_valid[0] && out_ready[0]) rx.push_back(out_data[0]);
    @(posedge clk);
    for (int d = 0; d < 2; d++) model_seq(d);
    #1;
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("out_valid%0d", d), 32'(out_valid[d]), 32'(m_ov[d]));
      chk($sformatf("out_data%0d", d), 32'(out_data[d]), 32'(m_od[d]));
      chk($sformatf("out_last%0d", d), 32'(out_last[d]), 32'(m_ol[d]));
      chk($sformatf("out_chan%0d", d), 32'(out_chan[d]), 32'(m_oc[d]));
      chk($sformatf("sel_err%0d", d), 32'(sel_err[d]), 32'(m_err[d]));
    end
  endtask

  task automatic set_beat(input int d, input int c, input logic [W-1:0] v, input logic l);
    in_data[d][c*W +: W] = v;
    in_valid[d][c] = 1'b1;
    in_last[d][c] = l;
  endtask

  int sb;
  int exp4[6] = '{0, 4, 9, 0, 4, 9};
  logic [W-1:0] frz;

  initial begin
    for (int d = 0; d < 2; d++) begin
      rst[d] = 1'b1; sel[d] = '0; in_data[d] = '0; in_valid[d] = '0;
      in_last[d] = '0; out_ready[d] = 1'b1;
      m_ov[d] = 0; m_ol[d] = 0; m_oc[d] = 0; m_od[d] = '0;
      m_err[d] = 0; m_lk[d] = 0; m_lch[d] = 0; m_ptr[d] = 0;
    end
    cycle();
    cycle();
    chk("rst_out_valid", 32'(out_valid[0]), 32'd0);
    chk("rst_out_data", 32'(out_data[0]), 32'd0);
    chk("rst_out_chan", 32'(out_chan[1]), 32'd0);
    chk("rst_sel_err", 32'(sel_err[0]), 32'd0);
    rst[0] = 1'b0;
    rst[1] = 1'b0;

    // select=3, four-beat packet on ch3
    sel[0] = 8'd3;
    for (int b = 0; b < 4; b++) begin
      set_beat(0, 3, W'(16'hA000 + b), (b == 3));
      cycle();
      chk("t1_data", 32'(out_data[0]), 32'hA000 + 32'(b));
      chk("t1_chan", 32'(out_chan[0]), 32'd3);
      chk("t1_last", 32'(out_last[0]), (b == 3) ? 32'd1 : 32'd0);
    end
    in_valid[0] = '0; in_last[0] = '0;
    cycle();
    chk("t1_idle_valid", 32'(out_valid[0]), 32'd0);

    // select moves 3->5 mid-packet; ch5 waits for ch3's last beat
    set_beat(0, 5, 16'hB000, 1'b1);
    for (int b = 0; b < 4; b++) begin
      if (b == 2) sel[0] = 8'd5;
      set_beat(0, 3, W'(16'hA010 + b), (b == 3));
      cycle();
      chk("t2_rdy_ch3", 32'(rdy_seen[0]), 32'h8);
    end
    in_valid[0][3] = 1'b0;
    cycle();
    chk("t2_rdy_ch5", 32'(rdy_seen[0]), 32'h20);
    chk("t2_chan5", 32'(out_chan[0]), 32'd5);
    in_valid[0] = '0; in_last[0] = '0;

    // out-of-range select
    for (int c = 0; c < CH; c++) set_beat(0, c, W'(16'hE000 + c), 1'b1);
    sel[0] = 8'd12;
    for (int i = 0; i < 2; i++) begin
      cycle();
      chk("t3_rdy", 32'(rdy_seen[0]), 32'd0);
      chk("t3_err", 32'(sel_err[0]), 32'd1);
      chk("t3_valid", 32'(out_valid[0]), 32'd0);
    end
    sel[0] = 8'd2;
    cycle();
    chk("t3_rdy2", 32'(rdy_seen[0]), 32'h4);
    chk("t3_err0", 32'(sel_err[0]), 32'd0);
    chk("t3_data2", 32'(out_data[0]), 32'hE002);
    in_valid[0] = '0; in_last[0] = '0;
    cycle();

    // backpressure mid-packet on ch1
    sel[0] = 8'd1;
    rx.delete();
    sb = 0;
    for (int t = 0; t < 16; t++) begin
      out_ready[0] = !(t >= 3 && t < 6);
      if (sb < 6) set_beat(0, 1, W'(16'hC000 + sb), (sb == 5));
      else in_valid[0] = '0;
      if (t == 3) frz = out_data[0];
      cycle();
      if (rdy_seen[0][1]) sb++;
      if (t >= 3 && t < 6) begin
        chk("t5_rdy_stall", 32'(rdy_seen[0]), 32'd0);
        chk("t5_frozen", 32'(out_data[0]), 32'(frz));
        chk("t5_chan", 32'(out_chan[0]), 32'd1);
      end
    end
    chk("t5_rx_count", 32'(rx.size()), 32'd6);
    for (int i = 0; i < 6 && i < rx.size(); i++)
      chk("t5_rx_data", 32'(rx[i]), 32'hC000 + 32'(i));
    in_valid[0] = '0; in_last[0] = '0;
    out_ready[0] = 1'b1;

    // MODE 1: single-beat packets on ch0, ch4, ch9
    set_beat(1, 0, 16'hD000, 1'b1);
    set_beat(1, 4, 16'hD004, 1'b1);
    set_beat(1, 9, 16'hD009, 1'b1);
    for (int i = 0; i < 6; i++) begin
      cycle();
      chk("t4_chan", 32'(out_chan[1]), 32'(exp4[i]));
    end
    in_valid[1] = '0; in_last[1] = '0;
    cycle();

    // lock on ch7, reset mid-packet, ch0 wins afterwards
    set_beat(1, 7, 16'hF007, 1'b0);
    cycle();
    cycle();
    chk("t6_lock_chan", 32'(out_chan[1]), 32'd7);
    set_beat(1, 0, 16'hF000, 1'b0);
    rst[1] = 1'b1;
    cycle();
    chk("t6_rst_valid", 32'(out_valid[1]), 32'd0);
    rst[1] = 1'b0;
    cycle();
    chk("t6_rdy_ch0", 32'(rdy_seen[1]), 32'h1);
    chk("t6_chan0", 32'(out_chan[1]), 32'd0);
    in_valid[1] = '0; in_last[1] = '0;

    // randomized traffic on both instances
    for (int t = 0; t < 400; t++) begin
      for (int d = 0; d < 2; d++) begin
        for (int c = 0; c < CH; c++) in_data[d][c*W +: W] = W'($urandom);
        in_valid[d] = CH'($urandom);
        in_last[d] = CH'($urandom) & CH'($urandom);
        out_ready[d] = ($urandom_range(0, 3) != 0);
        rst[d] = ($urandom_range(0, 99) == 0);
      end
      sel[0] = SW'($urandom_range(0, 11));
      sel[1] = SW'($urandom);
      cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
